// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB-management registers (Index, Random, EntryLo0/1, EntryHi) and the
// TLBP/TLBR/TLBWI/TLBWR sequencer driving the TLB probe, read and write ports.
module tlb_cp0_ctrl #(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,

    input  logic          cp0_we,
    input  logic [4:0]    cp0_waddr,
    input  logic [31:0]   cp0_wdata,
    input  logic [4:0]    cp0_raddr,
    output logic [31:0]   cp0_rdata,

    output logic [7:0]    cur_asid,

    output logic          probe_active,
    output logic [18:0]   s1_vpn2,
    output logic          s1_odd_page,
    output logic [7:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,

    output logic [IW-1:0] r_index,
    input  logic [18:0]   r_vpn2,
    input  logic [7:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_pfn0,
    input  logic [2:0]    r_c0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_pfn1,
    input  logic [2:0]    r_c1,
    input  logic          r_d1,
    input  logic          r_v1,

    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1
);

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROBE = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_idx_p;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_random;
    logic [25:0]     r_lo0;
    logic [25:0]     r_lo1;
    logic [18:0]     r_hi_vpn2;
    logic [7:0]      r_hi_asid;
    logic [1:0]      r_op;
    logic [IW-1:0]   r_wr_rand;

    logic            w_accept;
    logic            w_in_probe;
    logic            w_in_read;
    logic            w_mtc0_idx;
    logic            w_mtc0_lo0;
    logic            w_mtc0_lo1;
    logic            w_mtc0_hi;

    assign w_accept   = op_valid && (r_state == S_IDLE);
    assign w_in_probe = (r_state == S_PROBE);
    assign w_in_read  = (r_state == S_READ);

    // Software writes lose to a same-cycle hardware capture of the same register.
    assign w_mtc0_idx = cp0_we && (cp0_waddr == CP0_INDEX)    && !w_in_probe;
    assign w_mtc0_lo0 = cp0_we && (cp0_waddr == CP0_ENTRYLO0) && !w_in_read;
    assign w_mtc0_lo1 = cp0_we && (cp0_waddr == CP0_ENTRYLO1) && !w_in_read;
    assign w_mtc0_hi  = cp0_we && (cp0_waddr == CP0_ENTRYHI)  && !w_in_read;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    case (op_type)
                        OP_TLBP: w_next_state = S_PROBE;
                        OP_TLBR: w_next_state = S_READ;
                        default: w_next_state = S_WRITE;
                    endcase
                end
            end
            S_PROBE: w_next_state = S_DONE;
            S_READ:  w_next_state = S_DONE;
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded handshake and port qualifiers
    always_comb begin
        op_ready     = 1'b0;
        op_done      = 1'b0;
        we           = 1'b0;
        probe_active = 1'b0;
        case (r_state)
            S_IDLE:  op_ready     = 1'b1;
            S_PROBE: probe_active = 1'b1;
            S_WRITE: we           = 1'b1;
            S_DONE:  op_done      = 1'b1;
            default: ;
        endcase
    end

    // Random free-runs downward through every state, wrapping to the top entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_random <= IW'(TLBNUM - 1);
        end else if (r_random == '0) begin
            r_random <= IW'(TLBNUM - 1);
        end else begin
            r_random <= r_random - IW'(1);
        end
    end

    // Operation latch; TLBWR freezes its target index at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 2'd0;
            r_wr_rand <= '0;
        end else if (w_accept) begin
            r_op <= op_type;
            if (op_type == OP_TLBWR) begin
                r_wr_rand <= r_random;
            end
        end
    end

    // Index: MTC0 or probe result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx_p <= 1'b0;
            r_idx   <= '0;
        end else if (w_in_probe) begin
            r_idx_p <= ~s1_found;
            if (s1_found) begin
                r_idx <= s1_index;
            end
        end else if (w_mtc0_idx) begin
            r_idx_p <= cp0_wdata[31];
            r_idx   <= cp0_wdata[IW-1:0];
        end
    end

    // EntryHi / EntryLo0 / EntryLo1: MTC0 or TLBR capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo0     <= '0;
            r_lo1     <= '0;
            r_hi_vpn2 <= '0;
            r_hi_asid <= '0;
        end else if (w_in_read) begin
            r_hi_vpn2 <= r_vpn2;
            r_hi_asid <= r_asid;
            r_lo0     <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
            r_lo1     <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
        end else begin
            if (w_mtc0_lo0) begin
                r_lo0 <= cp0_wdata[25:0];
            end
            if (w_mtc0_lo1) begin
                r_lo1 <= cp0_wdata[25:0];
            end
            if (w_mtc0_hi) begin
                r_hi_vpn2 <= cp0_wdata[31:13];
                r_hi_asid <= cp0_wdata[7:0];
            end
        end
    end

    // MFC0 read mux
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_INDEX:    cp0_rdata = {r_idx_p, 31'(r_idx)};
            CP0_RANDOM:   cp0_rdata = 32'(r_random);
            CP0_ENTRYLO0: cp0_rdata = 32'(r_lo0);
            CP0_ENTRYLO1: cp0_rdata = 32'(r_lo1);
            CP0_ENTRYHI:  cp0_rdata = {r_hi_vpn2, 5'd0, r_hi_asid};
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign cur_asid    = r_hi_asid;

    assign s1_vpn2     = r_hi_vpn2;
    assign s1_odd_page = 1'b0;
    assign s1_asid     = r_hi_asid;

    assign r_index     = r_idx;

    assign w_index     = (r_op == OP_TLBWR) ? r_wr_rand : r_idx;
    assign w_vpn2      = r_hi_vpn2;
    assign w_asid      = r_hi_asid;
    assign w_g         = r_lo0[0] & r_lo1[0];
    assign w_pfn0      = r_lo0[25:6];
    assign w_c0        = r_lo0[5:3];
    assign w_d0        = r_lo0[2];
    assign w_v0        = r_lo0[1];
    assign w_pfn1      = r_lo1[25:6];
    assign w_c1        = r_lo1[5:3];
    assign w_d1        = r_lo1[2];
    assign w_v1        = r_lo1[1];

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Scoreboard bench for tlb_cp0_ctrl with a behavioural 16-entry TLB on the
// probe, read and write ports.
module tb_tlb_cp0_ctrl;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IW     = 4;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready;
    logic          op_done;
    logic          cp0_we;
    logic [4:0]    cp0_waddr;
    logic [31:0]   cp0_wdata;
    logic [4:0]    cp0_raddr;
    logic [31:0]   cp0_rdata;
    logic [7:0]    cur_asid;
    logic          probe_active;
    logic [18:0]   s1_vpn2;
    logic          s1_odd_page;
    logic [7:0]    s1_asid;
    logic          s1_found;
    logic [IW-1:0] s1_index;
    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0, r_pfn1;
    logic [2:0]    r_c0, r_c1;
    logic          r_d0, r_v0, r_d1, r_v1;
    logic          we;
    logic [IW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0, w_pfn1;
    logic [2:0]    w_c0, w_c1;
    logic          w_d0, w_v0, w_d1, w_v1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [18:0]   vpn2;
        logic [7:0]    asid;
        logic          g;
        logic [19:0]   pfn0;
        logic [2:0]    c0;
        logic          d0;
        logic          v0;
        logic [19:0]   pfn1;
        logic [2:0]    c1;
        logic          d1;
        logic          v1;
    } wr_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  n_cmp = 0;
    int  n_err = 0;

    tlb_cp0_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready), .op_done(op_done),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .cur_asid(cur_asid),
        .probe_active(probe_active), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page),
        .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TLB
    logic        m_valid [TLBNUM];
    logic [18:0] m_vpn2  [TLBNUM];
    logic [7:0]  m_asid  [TLBNUM];
    logic        m_g     [TLBNUM];
    logic [19:0] m_pfn0  [TLBNUM];
    logic [19:0] m_pfn1  [TLBNUM];
    logic [2:0]  m_c0    [TLBNUM];
    logic [2:0]  m_c1    [TLBNUM];
    logic        m_d0    [TLBNUM];
    logic        m_v0    [TLBNUM];
    logic        m_d1    [TLBNUM];
    logic        m_v1    [TLBNUM];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) m_valid[i] <= 1'b0;
        end else if (we) begin
            m_valid[w_index] <= 1'b1;
            m_vpn2[w_index]  <= w_vpn2;
            m_asid[w_index]  <= w_asid;
            m_g[w_index]     <= w_g;
            m_pfn0[w_index]  <= w_pfn0;
            m_c0[w_index]    <= w_c0;
            m_d0[w_index]    <= w_d0;
            m_v0[w_index]    <= w_v0;
            m_pfn1[w_index]  <= w_pfn1;
            m_c1[w_index]    <= w_c1;
            m_d1[w_index]    <= w_d1;
            m_v1[w_index]    <= w_v1;
        end
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (m_valid[i] && m_vpn2[i] == s1_vpn2 && (m_g[i] || m_asid[i] == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = IW'(i);
            end
        end
    end

    always_comb begin
        r_vpn2 = m_vpn2[r_index];
        r_asid = m_asid[r_index];
        r_g    = m_g[r_index];
        r_pfn0 = m_pfn0[r_index];
        r_c0   = m_c0[r_index];
        r_d0   = m_d0[r_index];
        r_v0   = m_v0[r_index];
        r_pfn1 = m_pfn1[r_index];
        r_c1   = m_c1[r_index];
        r_d1   = m_d1[r_index];
        r_v1   = m_v1[r_index];
    end

    function automatic wr_t cur_write();
        return {w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                w_pfn1, w_c1, w_d1, w_v1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_waddr = a;
        cp0_wdata = d;
        tick();
        cp0_we    = 1'b0;
    endtask

    // Presents a request for one cycle; returns in the execute cycle
    task automatic issue(input logic [1:0] t);
        op_valid = 1'b1;
        op_type  = t;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({op_ready, op_done, we, probe_active} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 1000", {op_ready, op_done, we, probe_active});
        end
        reset = 1'b0;
        cp0_raddr = 5'd1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cp0_rdata !== 32'(15 - i)) begin
                n_err++;
                $display("FAIL random_count%0d: got %0d want %0d", i, cp0_rdata, 15 - i);
            end
            tick();
        end
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (cp0_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL random_zero: got %0d want 0", cp0_rdata);
        end
        tick();
        n_cmp++;
        if (cp0_rdata !== 32'd15) begin
            n_err++;
            $display("FAIL random_wrap: got %0d want 15", cp0_rdata);
        end
        rd(5'd0, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL reset_index: got %h want 00000000", d);
        end
        rd(5'd10, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL reset_entryhi: got %h want 00000000", d);
        end
    endtask

    task automatic test_tlbwi();
        wr_t e;
        mtc0(5'd10, 32'h0040_2005);
        mtc0(5'd2,  32'h0000_0107);
        mtc0(5'd3,  32'h0000_0147);
        mtc0(5'd0,  32'h0000_0003);
        wq.push_back('{idx: 4'd3, vpn2: 19'h201, asid: 8'h05, g: 1'b1,
                       pfn0: 20'h4, c0: 3'd0, d0: 1'b1, v0: 1'b1,
                       pfn1: 20'h5, c1: 3'd0, d1: 1'b1, v1: 1'b1});
        n_cmp++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wi_ready: got %b want 1", op_ready);
        end
        issue(2'd2);
        n_cmp++;
        if (we !== 1'b1 || wq.size() == 0) begin
            n_err++;
            $display("FAIL wi_we: got %b want 1", we);
        end else begin
            e = wq.pop_front();
            n_cmp++;
            if (cur_write() !== e) begin
                n_err++;
                $display("FAIL wi_data: got %h want %h", cur_write(), e);
            end
        end
        tick();
        n_cmp++;
        if ({we, op_done, op_ready} !== 3'b010) begin
            n_err++;
            $display("FAIL wi_done: got %b want 010", {we, op_done, op_ready});
        end
        tick();
        n_cmp++;
        if ({we, op_done, op_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL wi_idle: got %b want 001", {we, op_done, op_ready});
        end
    endtask

    task automatic test_tlbp();
        rd_t         e;
        logic [31:0] d;
        // Hit on entry 3
        mtc0(5'd0, 32'h0);
        rq.push_back('{addr: 5'd0, data: 32'h0000_0003});
        issue(2'd0);
        n_cmp++;
        if ({probe_active, s1_vpn2, s1_odd_page, s1_asid} !== {1'b1, 19'h201, 1'b0, 8'h05}) begin
            n_err++;
            $display("FAIL probe_port: got %h want %h", {probe_active, s1_vpn2, s1_odd_page, s1_asid},
                     {1'b1, 19'h201, 1'b0, 8'h05});
        end
        tick();
        n_cmp++;
        if (op_done !== 1'b1) begin
            n_err++;
            $display("FAIL probe_done: got %b want 1", op_done);
        end
        while (rq.size() > 0) begin
            e = rq.pop_front();
            rd(e.addr, d);
            n_cmp++;
            if (d !== e.data) begin
                n_err++;
                $display("FAIL probe_hit_reg%0d: got %h want %h", e.addr, d, e.data);
            end
        end
        tick();
        // Miss: P set, index kept
        mtc0(5'd10, 32'h1234_6005);
        rq.push_back('{addr: 5'd0, data: 32'h8000_0003});
        issue(2'd0);
        tick();
        while (rq.size() > 0) begin
            e = rq.pop_front();
            rd(e.addr, d);
            n_cmp++;
            if (d !== e.data) begin
                n_err++;
                $display("FAIL probe_miss_reg%0d: got %h want %h", e.addr, d, e.data);
            end
        end
        tick();
    endtask

    task automatic test_tlbr();
        rd_t         e;
        logic [31:0] d;
        mtc0(5'd10, 32'h0);
        mtc0(5'd2,  32'h0);
        mtc0(5'd3,  32'h0);
        mtc0(5'd0,  32'h3);
        rq.push_back('{addr: 5'd10, data: 32'h0040_2005});
        rq.push_back('{addr: 5'd2,  data: 32'h0000_0107});
        rq.push_back('{addr: 5'd3,  data: 32'h0000_0147});
        issue(2'd1);
        n_cmp++;
        if (r_index !== 4'd3) begin
            n_err++;
            $display("FAIL read_index: got %0d want 3", r_index);
        end
        tick();
        n_cmp++;
        if (op_done !== 1'b1) begin
            n_err++;
            $display("FAIL read_done: got %b want 1", op_done);
        end
        while (rq.size() > 0) begin
            e = rq.pop_front();
            rd(e.addr, d);
            n_cmp++;
            if (d !== e.data) begin
                n_err++;
                $display("FAIL read_reg%0d: got %h want %h", e.addr, d, e.data);
            end
        end
        tick();
    endtask

    task automatic test_tlbwr();
        wr_t e;
        int  cnt;
        mtc0(5'd10, 32'h0080_4011);
        mtc0(5'd2,  32'h0000_0203);
        mtc0(5'd3,  32'h0000_0286);
        wq.push_back('{idx: 4'd7, vpn2: 19'h402, asid: 8'h11, g: 1'b0,
                       pfn0: 20'h8, c0: 3'd0, d0: 1'b0, v0: 1'b1,
                       pfn1: 20'hA, c1: 3'd0, d1: 1'b1, v1: 1'b1});
        cp0_raddr = 5'd1;
        #1;
        cnt = 0;
        while (cp0_rdata !== 32'd7 && cnt < 40) begin
            tick();
            cnt++;
        end
        n_cmp++;
        if (cnt >= 40) begin
            n_err++;
            $display("FAIL wr_random_wait: got %0d want 7", cp0_rdata);
        end
        op_valid = 1'b1;
        op_type  = 2'd3;
        tick();
        op_valid = 1'b0;
        n_cmp++;
        if (cp0_rdata !== 32'd6) begin
            n_err++;
            $display("FAIL wr_random_moved: got %0d want 6", cp0_rdata);
        end
        n_cmp++;
        if (we !== 1'b1 || wq.size() == 0) begin
            n_err++;
            $display("FAIL wr_we: got %b want 1", we);
        end else begin
            e = wq.pop_front();
            n_cmp++;
            if (cur_write() !== e) begin
                n_err++;
                $display("FAIL wr_data: got %h want %h", cur_write(), e);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        wr_t         w;
        rd_t         e;
        logic [31:0] d;
        mtc0(5'd0,  32'h5);
        mtc0(5'd10, 32'h00A0_0022);
        mtc0(5'd2,  32'h0000_0145);
        mtc0(5'd3,  32'h0000_0181);
        wq.push_back('{idx: 4'd5, vpn2: 19'h500, asid: 8'h22, g: 1'b1,
                       pfn0: 20'h5, c0: 3'd0, d0: 1'b1, v0: 1'b0,
                       pfn1: 20'h6, c1: 3'd0, d1: 1'b0, v1: 1'b0});
        rq.push_back('{addr: 5'd0, data: 32'h0000_0005});
        op_valid = 1'b1;
        op_type  = 2'd2;
        tick();
        op_type  = 2'd0;
        n_cmp++;
        if ({we, op_ready} !== 2'b10 || wq.size() == 0) begin
            n_err++;
            $display("FAIL b2b_write: got %b want 10", {we, op_ready});
        end else begin
            w = wq.pop_front();
            n_cmp++;
            if (cur_write() !== w) begin
                n_err++;
                $display("FAIL b2b_wdata: got %h want %h", cur_write(), w);
            end
        end
        tick();
        n_cmp++;
        if ({op_done, op_ready, probe_active} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_hold: got %b want 100", {op_done, op_ready, probe_active});
        end
        tick();
        n_cmp++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got %b want 1", op_ready);
        end
        tick();
        op_valid = 1'b0;
        n_cmp++;
        if (probe_active !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_probe: got %b want 1", probe_active);
        end
        tick();
        while (rq.size() > 0) begin
            e = rq.pop_front();
            rd(e.addr, d);
            n_cmp++;
            if (d !== e.data) begin
                n_err++;
                $display("FAIL b2b_reg%0d: got %h want %h", e.addr, d, e.data);
            end
        end
        tick();
    endtask

    task automatic test_collision();
        rd_t         e;
        logic [31:0] d;
        mtc0(5'd0, 32'h0);
        rq.push_back('{addr: 5'd0, data: 32'h0000_0005});
        issue(2'd0);
        cp0_we    = 1'b1;
        cp0_waddr = 5'd0;
        cp0_wdata = 32'h0000_0009;
        tick();
        cp0_we    = 1'b0;
        while (rq.size() > 0) begin
            e = rq.pop_front();
            rd(e.addr, d);
            n_cmp++;
            if (d !== e.data) begin
                n_err++;
                $display("FAIL collision_reg%0d: got %h want %h", e.addr, d, e.data);
            end
        end
        tick();
    endtask

    task automatic test_reset_midop();
        mtc0(5'd0, 32'h6);
        issue(2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cp0_raddr = 5'd1;
        #1;
        n_cmp++;
        if (cp0_rdata !== 32'd15) begin
            n_err++;
            $display("FAIL abort_random: got %0d want 15", cp0_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({we, op_done, op_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL abort_cycle%0d: got %b want 001", i, {we, op_done, op_ready});
            end
            tick();
        end
        n_cmp++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d want 0", wq.size() + rq.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_type   = 2'd0;
        cp0_we    = 1'b0;
        cp0_waddr = 5'd0;
        cp0_wdata = 32'd0;
        cp0_raddr = 5'd0;
        test_reset();
        test_tlbwi();
        test_tlbp();
        test_tlbr();
        test_tlbwr();
        test_back_to_back();
        test_collision();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
